// File: rtl/case_3_acc_pkg.sv
// Shared types and signed add helpers for the product accumulator.
// Build option: CASE_3_ACC_SATURATE_EN selects clamping instead of wrap.
package case_3_acc_pkg;

  typedef enum logic {ACC, HOLD} acc_state_t;

  localparam int MAX_W = 64;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic wide_t ACC_MAX(input int w);
    return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t ACC_MIN(input int w);
    return -(wide_t'(1) <<< (w - 1));
  endfunction

  // Operands lie in the w-bit range, so the wide sum leaving that range
  // is the same event as equal operand signs giving a flipped result sign.
  function automatic logic [MAX_W:0] sat_add(
    input wide_t a,
    input wide_t b,
    input logic  sat,
    input int    w
  );
    wide_t s;
    wide_t hi;
    wide_t lo;
    logic  ovf;
    s   = a + b;
    hi  = ACC_MAX(w);
    lo  = ACC_MIN(w);
    ovf = (s > hi) || (s < lo);
    if (ovf && sat)
      s = (s > hi) ? hi : lo;
    else if (ovf)
      s = (s > hi) ? s - (hi - lo + wide_t'(1))
                   : s + (hi - lo + wide_t'(1));
    return {ovf, s};
  endfunction

endpackage

// File: rtl/case_3_acc_10s_n_terms.sv
// Sums N_TERMS signed products per result behind valid/ready handshakes.
// Build option: CASE_3_ACC_SATURATE_EN clamps overflowing adds.
module case_3_acc_10s_n_terms
  import case_3_acc_pkg::*;
#(
  parameter int DIN_W   = 10,
  parameter int ACC_W   = 18,
  parameter int N_TERMS = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic signed [DIN_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_ovf
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

`ifdef CASE_3_ACC_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  acc_state_t              state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic        [CNT_W-1:0] cnt_q;
  logic                    ovf_q;
  logic signed [ACC_W-1:0] data_q;
  logic                    oovf_q;
  logic        [MAX_W:0]   sum_w;
  logic                    ovf_this;
  logic                    unused_bits;

  assign sum_w = sat_add(wide_t'(acc_q), wide_t'(in_data), SAT, ACC_W);
  assign acc_d       = sum_w[ACC_W-1:0];
  assign ovf_this    = sum_w[MAX_W];
  assign unused_bits = ^sum_w[MAX_W-1:ACC_W];

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_ovf   = oovf_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              data_q  <= acc_d;
              oovf_q  <= ovf_q | ovf_this;
              acc_q   <= '0;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              state_q <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
              ovf_q <= ovf_q | ovf_this;
            end
          end
        end
        HOLD: begin
          if (out_ready)
            state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_case_3_acc_10s_n_terms.sv
// Bench for the product accumulator: three configurations, a frame-level
// reference model, directed literal cases and a randomized phase.
module tb_case_3_acc_10s_n_terms;

`ifdef CASE_3_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // instance 0: N=4 W=18, instance 1: N=4 W=11, instance 2: N=1 W=18
  int N [3] = '{4, 4, 1};
  int W [3] = '{18, 11, 18};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [9:0] din  [3];
  logic              vld  [3];
  logic              rdy  [3];
  logic              ov   [3];
  logic              ordy [3];
  logic              ovf  [3];
  logic signed [17:0] od0;
  logic signed [10:0] od1;
  logic signed [17:0] od2;
  int                 odv [3];

  assign odv[0] = int'(od0);
  assign odv[1] = int'(od1);
  assign odv[2] = int'(od2);

  case_3_acc_10s_n_terms #(.DIN_W(10), .ACC_W(18), .N_TERMS(4)) u0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .out_data(od0), .out_valid(ov[0]), .out_ready(ordy[0]), .out_ovf(ovf[0])
  );

  case_3_acc_10s_n_terms #(.DIN_W(10), .ACC_W(11), .N_TERMS(4)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .out_data(od1), .out_valid(ov[1]), .out_ready(ordy[1]), .out_ovf(ovf[1])
  );

  case_3_acc_10s_n_terms #(.DIN_W(10), .ACC_W(18), .N_TERMS(1)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .out_data(od2), .out_valid(ov[2]), .out_ready(ordy[2]), .out_ovf(ovf[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame terms are kept, and the result is folded from the
  // whole frame when its last term arrives.
  int  terms [3][16];
  int  mcnt  [3];
  bit  mhold [3];
  int  mexp  [3];
  bit  mexpo [3];

  function automatic void fold(input int i, input int last, output int s, output bit o);
    int hi;
    int lo;
    int v;
    hi = (1 << (W[i] - 1)) - 1;
    lo = -(1 << (W[i] - 1));
    s = 0;
    o = 1'b0;
    for (int k = 0; k < N[i]; k++) begin
      v = (k == N[i] - 1) ? last : terms[i][k];
      s = s + v;
      if (s > hi || s < lo) begin
        o = 1'b1;
        if (SAT) s = (s > hi) ? hi : lo;
        else     s = (s > hi) ? s - (1 << W[i]) : s + (1 << W[i]);
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int s;
    bit o;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i]  <= 0;
        mhold[i] <= 1'b0;
        mexp[i]  <= 0;
        mexpo[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!mhold[i]) begin
          if (vld[i]) begin
            if (mcnt[i] == N[i] - 1) begin
              fold(i, int'(din[i]), s, o);
              mexp[i]  <= s;
              mexpo[i] <= o;
              mhold[i] <= 1'b1;
              mcnt[i]  <= 0;
            end else begin
              terms[i][mcnt[i]] <= int'(din[i]);
              mcnt[i] <= mcnt[i] + 1;
            end
          end
        end else if (ordy[i]) begin
          mhold[i] <= 1'b0;
        end
      end
    end
  end

  bit started = 1'b0;

  always @(negedge clk) begin
    if (started && rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk(rdy[i] == !mhold[i], $sformatf("cmp_in_ready[%0d]", i), int'(rdy[i]), int'(!mhold[i]));
        chk(ov[i] == mhold[i], $sformatf("cmp_out_valid[%0d]", i), int'(ov[i]), int'(mhold[i]));
        if (mhold[i]) begin
          chk(odv[i] == mexp[i], $sformatf("cmp_out_data[%0d]", i), odv[i], mexp[i]);
          chk(ovf[i] == mexpo[i], $sformatf("cmp_out_ovf[%0d]", i), int'(ovf[i]), int'(mexpo[i]));
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the accept.
  task automatic send(input int i, input int v);
    int n;
    n = 0;
    din[i] = 10'(v);
    vld[i] = 1'b1;
    while (!rdy[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(1'b0, "send_timeout", n, 200);
    @(negedge clk);
    vld[i] = 1'b0;
  endtask

  task automatic expect_out(input int i, input int d, input bit o, input string name);
    chk(ov[i] == 1'b1, {name, "_valid"}, int'(ov[i]), 1);
    chk(odv[i] == d, {name, "_data"}, odv[i], d);
    chk(ovf[i] == o, {name, "_ovf"}, int'(ovf[i]), int'(o));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0;
      vld[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    #1;
    chk(rdy[0] == 1'b1, "reset_in_ready", int'(rdy[0]), 1);
    chk(ov[0] == 1'b0, "reset_out_valid", int'(ov[0]), 0);
    chk(odv[0] == 0, "reset_out_data", odv[0], 0);
    chk(ovf[0] == 1'b0, "reset_out_ovf", int'(ovf[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    started = 1'b1;
    @(negedge clk);

    // basic sum
    send(0, 100); send(0, -50); send(0, 511); send(0, -512);
    expect_out(0, 49, 1'b0, "basic");
    @(negedge clk);
    chk(rdy[0] == 1'b1, "basic_ready_back", int'(rdy[0]), 1);

    // bubbles and backpressure
    send(0, 100);
    repeat (2) @(negedge clk);
    send(0, -50); send(0, 511);
    @(negedge clk);
    ordy[0] = 1'b0;
    send(0, -512);
    expect_out(0, 49, 1'b0, "stall");
    din[0] = 10'sd9;
    vld[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(rdy[0] == 1'b0, "stall_in_ready", int'(rdy[0]), 0);
      chk(odv[0] == 49, "stall_out_data", odv[0], 49);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk(rdy[0] == 1'b1, "stall_release", int'(rdy[0]), 1);
    @(negedge clk);
    vld[0] = 1'b0;
    send(0, 1); send(0, 1); send(0, 1);
    expect_out(0, 12, 1'b0, "after_stall");

    // positive overflow, 11-bit accumulator
    send(1, 511); send(1, 511); send(1, 511); send(1, 0);
    expect_out(1, SAT ? 1023 : -515, 1'b1, "pos_ovf");

    // negative extreme, 11-bit accumulator
    send(1, -512); send(1, -512); send(1, -512); send(1, -512);
    expect_out(1, SAT ? -1024 : 0, 1'b1, "neg_ovf");
    @(negedge clk);

    // reset mid-frame
    send(0, 7); send(0, 7);
    #2 rst_n = 1'b0;
    #1;
    chk(ov[0] == 1'b0, "midreset_out_valid", int'(ov[0]), 0);
    chk(rdy[0] == 1'b1, "midreset_in_ready", int'(rdy[0]), 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    expect_out(0, 10, 1'b0, "post_reset");
    @(negedge clk);

    // single-term frames, back-to-back
    din[2] = 10'sd5;
    vld[2] = 1'b1;
    @(negedge clk);
    expect_out(2, 5, 1'b0, "n1_first");
    chk(rdy[2] == 1'b0, "n1_hold_ready", int'(rdy[2]), 0);
    din[2] = -10'sd3;
    @(negedge clk);
    chk(ov[2] == 1'b0, "n1_gap_valid", int'(ov[2]), 0);
    @(negedge clk);
    vld[2] = 1'b0;
    expect_out(2, -3, 1'b0, "n1_second");
    @(negedge clk);

    // randomized traffic on all instances
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        vld[i]  = ($urandom_range(0, 3) != 0);
        din[i]  = 10'($urandom_range(0, 1023));
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
